// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_feeder
// Description : Skews A column / B row slices into an NxN systolic array,
//               tile by tile, with drain and anti-diagonal push sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_feeder #(
    parameter int DW     = 8,
    parameter int N      = 2,
    parameter int SIZE_W = 17
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [SIZE_W-1:0]          size,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N*DW-1:0]            in_a,
    input  logic [N*DW-1:0]            in_b,
    output logic [N*DW-1:0]            a_out,
    output logic [N*DW-1:0]            b_out,
    output logic                       feed_valid,
    output logic                       tile_first,
    output logic                       push,
    output logic [$clog2(2*N-1)-1:0]   push_diag,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int PW = $clog2(2*N-1);
    localparam logic [SIZE_W-1:0]   c_n          = SIZE_W'(N);
    localparam logic [SIZE_W-1:0]   c_one        = {{(SIZE_W-1){1'b0}}, 1'b1};
    localparam logic [2*SIZE_W-1:0] c_tile_one   = {{(2*SIZE_W-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]       c_ph_one     = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]       c_drain_last = PW'(N-2);
    localparam logic [PW-1:0]       c_push_last  = PW'(2*N-2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_PUSH  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state, w_next;
    logic [SIZE_W-1:0]     r_size, r_beat, w_quot;
    logic [2*SIZE_W-1:0]   r_tiles, r_tile_cnt, w_tiles;
    logic [PW-1:0]         r_phase;
    logic                  r_feed_valid, r_tile_first, r_err;
    logic                  w_legal, w_start_ok, w_accept, w_shift, w_clr, w_abort;
    logic                  w_last_beat, w_drain_end, w_push_end, w_last_tile;

    assign w_legal     = (size >= c_n) && ((size % c_n) == '0);
    assign w_quot      = size / c_n;
    assign w_tiles     = {{SIZE_W{1'b0}}, w_quot} * {{SIZE_W{1'b0}}, w_quot};
    assign w_start_ok  = (r_state == S_IDLE) && start && w_legal;
    assign w_abort     = (r_state != S_IDLE) && abort;
    assign w_accept    = (r_state == S_RUN) && in_valid && !abort;
    assign w_shift     = w_accept || ((r_state == S_DRAIN) && !abort);
    assign w_last_beat = (r_beat == (r_size - c_one));
    assign w_drain_end = (r_state == S_DRAIN) && (r_phase == c_drain_last);
    assign w_push_end  = (r_state == S_PUSH) && (r_phase == c_push_last);
    assign w_last_tile = ((r_tile_cnt + c_tile_one) == r_tiles);
    // Skew lanes are wiped on every tile boundary so each tile starts from zeros.
    assign w_clr       = w_start_ok || w_abort || (w_push_end && !abort && !w_last_tile);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        push      = 1'b0;
        push_diag = '0;
        if (w_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start_ok) w_next = S_RUN;
                S_RUN:   if (w_accept && w_last_beat) w_next = S_DRAIN;
                S_DRAIN: if (w_drain_end) w_next = S_PUSH;
                S_PUSH:  if (w_push_end) w_next = w_last_tile ? S_DONE : S_RUN;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
        case (r_state)
            S_RUN:   begin in_ready = 1'b1; busy = 1'b1; end
            S_DRAIN: busy = 1'b1;
            S_PUSH:  begin busy = 1'b1; push = 1'b1; push_diag = r_phase; end
            S_DONE:  begin busy = 1'b1; done = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_size       <= '0;
            r_tiles      <= '0;
            r_beat       <= '0;
            r_phase      <= '0;
            r_tile_cnt   <= '0;
            r_feed_valid <= 1'b0;
            r_tile_first <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_err        <= (r_state == S_IDLE) && start && !w_legal;
            r_feed_valid <= w_shift;
            r_tile_first <= w_accept && (r_beat == '0);
            if (w_abort) begin
                r_beat     <= '0;
                r_phase    <= '0;
                r_tile_cnt <= '0;
            end else if (w_start_ok) begin
                r_size     <= size;
                r_tiles    <= w_tiles;
                r_beat     <= '0;
                r_phase    <= '0;
                r_tile_cnt <= '0;
            end else begin
                if (w_accept) begin
                    r_beat <= w_last_beat ? '0 : r_beat + c_one;
                end
                if (w_drain_end || w_push_end) begin
                    r_phase <= '0;
                end else if ((r_state == S_DRAIN) || (r_state == S_PUSH)) begin
                    r_phase <= r_phase + c_ph_one;
                end
                if (w_push_end) begin
                    r_tile_cnt <= r_tile_cnt + c_tile_one;
                end
            end
        end
    end

    assign feed_valid = r_feed_valid;
    assign tile_first = r_tile_first;
    assign err        = r_err;

    // Lane i is an (i+1)-deep delay line; its last stage drives the array edge.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW-1:0] r_a_dly [i+1];
        logic [DW-1:0] r_b_dly [i+1];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int k = 0; k <= i; k++) begin
                    r_a_dly[k] <= '0;
                    r_b_dly[k] <= '0;
                end
            end else if (w_clr) begin
                for (int k = 0; k <= i; k++) begin
                    r_a_dly[k] <= '0;
                    r_b_dly[k] <= '0;
                end
            end else if (w_shift) begin
                r_a_dly[0] <= w_accept ? in_a[i*DW +: DW] : '0;
                r_b_dly[0] <= w_accept ? in_b[i*DW +: DW] : '0;
                for (int k = 1; k <= i; k++) begin
                    r_a_dly[k] <= r_a_dly[k-1];
                    r_b_dly[k] <= r_b_dly[k-1];
                end
            end
        end

        assign a_out[i*DW +: DW] = r_a_dly[i];
        assign b_out[i*DW +: DW] = r_b_dly[i];
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_feeder
// Description : Directed self-checking bench for systolic_feeder (N=2 and N=4).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_systolic_feeder;

    localparam int DW  = 8;
    localparam int N   = 2;
    localparam int SW  = 17;
    localparam int PW  = $clog2(2*N-1);
    localparam int DW1 = 16;
    localparam int N1  = 4;
    localparam int PW1 = $clog2(2*N1-1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic            start, abort, in_valid, in_ready;
    logic [SW-1:0]   size;
    logic [N*DW-1:0] in_a, in_b, a_out, b_out;
    logic            feed_valid, tile_first, push, busy, done, err;
    logic [PW-1:0]   push_diag;

    logic              start1, abort1, in_valid1, in_ready1;
    logic [SW-1:0]     size1;
    logic [N1*DW1-1:0] in_a1, in_b1, a_out1, b_out1;
    logic              feed_valid1, tile_first1, push1, busy1, done1, err1;
    logic [PW1-1:0]    push_diag1;

    systolic_feeder #(.DW(DW), .N(N), .SIZE_W(SW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .size(size),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .a_out(a_out), .b_out(b_out), .feed_valid(feed_valid), .tile_first(tile_first),
        .push(push), .push_diag(push_diag), .busy(busy), .done(done), .err(err)
    );

    systolic_feeder #(.DW(DW1), .N(N1), .SIZE_W(SW)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1), .size(size1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
        .a_out(a_out1), .b_out(b_out1), .feed_valid(feed_valid1), .tile_first(tile_first1),
        .push(push1), .push_diag(push_diag1), .busy(busy1), .done(done1), .err(err1)
    );

    int errors = 0;
    int checks = 0;
    int n_acc, n_fv, n_tf, n_push, n_done, n_err, diag_bad, exp_diag;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_tally();
        n_acc = 0; n_fv = 0; n_tf = 0; n_push = 0; n_done = 0; n_err = 0;
        diag_bad = 0; exp_diag = 0;
    endtask

    // One clock of the N=2 unit, tallying what it did on that edge.
    task automatic cyc();
        logic acc;
        acc = in_valid && in_ready;
        @(posedge clk); #1;
        if (acc) n_acc++;
        if (feed_valid) n_fv++;
        if (tile_first) n_tf++;
        if (push) begin
            if (push_diag !== PW'(exp_diag)) diag_bad++;
            exp_diag = (exp_diag == 2*N-2) ? 0 : exp_diag + 1;
            n_push++;
        end
        if (done) n_done++;
        if (err) n_err++;
    endtask

    int s1, nb1, n_drain1, n_push1, n_done1, first_nz, exp_d1, diag_bad1;
    logic acc1, drain1;
    logic [15:0] exp16, expb16;

    initial begin
        reset = 1'b1; start = 0; abort = 0; size = '0; in_valid = 0; in_a = '0; in_b = '0;
        start1 = 0; abort1 = 0; size1 = '0; in_valid1 = 0; in_a1 = '0; in_b1 = '0;
        clr_tally();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 0);
        check("rst_fv", feed_valid, 0);
        check("rst_push", {push, push_diag, done, err, tile_first}, 0);
        check("rst_data", {a_out, b_out}, 0);
        reset = 1'b0;

        // Basic M=2 run with a start-while-busy probe
        clr_tally();
        start = 1; size = 2; in_valid = 1; in_a = 16'hEEEE; in_b = 16'hEEEE;
        cyc();
        check("m2_busy", busy, 1);
        check("m2_ready", in_ready, 1);
        check("m2_fv0", feed_valid, 0);
        start = 0; in_a = {8'h21, 8'h11}; in_b = {8'h41, 8'h31};
        cyc();
        check("m2_a_s0", a_out, {8'h00, 8'h11});
        check("m2_b_s0", b_out, {8'h00, 8'h31});
        check("m2_tf_s0", {feed_valid, tile_first}, 2'b11);
        start = 1; size = 3; in_a = {8'h22, 8'h12}; in_b = {8'h42, 8'h32};
        cyc();
        check("m2_a_s1", a_out, {8'h21, 8'h12});
        check("m2_b_s1", b_out, {8'h41, 8'h32});
        check("m2_tf_s1", {feed_valid, tile_first}, 2'b10);
        check("busy_start_no_err", err, 0);
        check("m2_drain_ready", in_ready, 0);
        start = 0; in_a = 16'hEEEE; in_b = 16'hEEEE;
        cyc();
        check("m2_a_s2", a_out, {8'h22, 8'h00});
        check("m2_b_s2", b_out, {8'h42, 8'h00});
        check("m2_push0", {feed_valid, push, push_diag}, {1'b1, 1'b1, 2'd0});
        cyc();
        check("m2_push1", {feed_valid, push, push_diag}, {1'b0, 1'b1, 2'd1});
        cyc(); cyc();
        check("m2_done", {done, busy}, 2'b11);
        cyc();
        check("m2_idle", {done, busy}, 2'b00);
        check("m2_beats", n_acc, 2);
        check("m2_fv_cnt", n_fv, 3);
        check("m2_push_cnt", n_push, 3);
        check("m2_diag", diag_bad, 0);
        check("m2_done_cnt", n_done, 1);
        check("m2_err_cnt", n_err, 0);

        // M=4: four tiles
        clr_tally();
        start = 1; size = 4; in_valid = 1;
        cyc();
        start = 0;
        for (int k = 0; k < 200 && n_done == 0; k++) begin
            in_a = 16'($urandom); in_b = 16'($urandom);
            cyc();
        end
        cyc();
        check("m4_done_cnt", n_done, 1);
        check("m4_beats", n_acc, 16);
        check("m4_tiles", n_tf, 4);
        check("m4_fv_cnt", n_fv, 20);
        check("m4_push_cnt", n_push, 12);
        check("m4_diag", diag_bad, 0);
        check("m4_idle", busy, 0);

        // Stall mid-tile
        clr_tally();
        start = 1; size = 2; in_valid = 1;
        cyc();
        start = 0; in_a = {8'h81, 8'h01}; in_b = {8'hC3, 8'hA5};
        cyc();
        check("st_a_s0", a_out, {8'h00, 8'h01});
        in_valid = 0; in_a = 16'h5555; in_b = 16'h5555;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("st_hold_fv", {feed_valid, tile_first}, 2'b00);
            check("st_hold_a", a_out, {8'h00, 8'h01});
            check("st_hold_b", b_out, {8'h00, 8'hA5});
        end
        in_valid = 1; in_a = {8'hFF, 8'h7F}; in_b = {8'h0F, 8'hF0};
        cyc();
        check("st_a_s1", a_out, {8'h81, 8'h7F});
        check("st_b_s1", b_out, {8'hC3, 8'hF0});
        in_a = 16'h5555; in_b = 16'h5555;
        cyc();
        check("st_a_s2", a_out, {8'hFF, 8'h00});
        check("st_b_s2", b_out, {8'h0F, 8'h00});
        for (int k = 0; k < 20 && busy; k++) cyc();
        check("st_idle", busy, 0);
        check("st_counts", {n_acc[7:0], n_fv[7:0], n_done[7:0]}, {8'd2, 8'd3, 8'd1});

        // Illegal sizes
        clr_tally();
        in_valid = 0; start = 1; size = 3;
        cyc();
        check("err_m3", {err, busy}, 2'b10);
        start = 0;
        cyc();
        check("err_m3_pulse", err, 0);
        start = 1; size = 0;
        cyc();
        check("err_m0", {err, busy}, 2'b10);
        start = 0;
        cyc();
        check("err_m0_pulse", {err, busy}, 2'b00);

        // Abort in DRAIN, then abort+start together in IDLE
        clr_tally();
        start = 1; size = 2; in_valid = 1; in_a = {8'h21, 8'h11}; in_b = {8'h41, 8'h31};
        cyc();
        start = 0;
        cyc(); cyc();
        check("ab_in_drain", {busy, in_ready}, 2'b10);
        abort = 1;
        cyc();
        abort = 0;
        check("ab_idle", {busy, feed_valid, push, done}, 4'b0000);
        check("ab_cleared", {a_out, b_out}, 0);
        abort = 1; start = 1; size = 2;
        cyc();
        check("ab_start_wins", busy, 1);
        abort = 0; start = 0; in_a = {8'hB2, 8'hA1}; in_b = {8'hD4, 8'hC3};
        cyc();
        check("ab_a_s0", a_out, {8'h00, 8'hA1});
        check("ab_b_s0", b_out, {8'h00, 8'hC3});
        check("ab_tf", tile_first, 1);
        for (int k = 0; k < 20 && busy; k++) cyc();
        check("ab_idle_end", busy, 0);
        check("ab_done_cnt", n_done, 1);

        // Reset mid-operation
        clr_tally();
        start = 1; size = 2; in_valid = 1;
        cyc();
        start = 0; in_a = {8'h21, 8'h11};
        cyc();
        #2 reset = 1;
        #1;
        check("rr_async", {busy, in_ready, feed_valid, tile_first, push, done, err}, 0);
        check("rr_data", {a_out, b_out, push_diag}, 0);
        @(posedge clk); #1;
        reset = 0;
        clr_tally();
        repeat (10) cyc();
        check("rr_no_done", {n_done[7:0], busy}, 0);

        // N=4, DW=16, M=4
        start1 = 1; size1 = 4; in_valid1 = 1;
        @(posedge clk); #1;
        start1 = 0;
        s1 = 0; nb1 = 0; n_drain1 = 0; n_push1 = 0; n_done1 = 0;
        first_nz = -1; exp_d1 = 0; diag_bad1 = 0;
        for (int k = 0; k < 40 && n_done1 == 0; k++) begin
            for (int i = 0; i < N1; i++) begin
                in_a1[i*DW1 +: DW1] = 16'(16'h0100 * (nb1 + 1) + i + 1);
                in_b1[i*DW1 +: DW1] = 16'(16'h8000 + 16'h0100 * (nb1 + 1) + i + 1);
            end
            acc1   = in_valid1 && in_ready1;
            drain1 = busy1 && !in_ready1 && !push1 && !done1;
            @(posedge clk); #1;
            if (acc1) nb1++;
            if (drain1) n_drain1++;
            if (feed_valid1) begin
                exp16  = (s1 >= 3 && s1 <= 6) ? 16'(16'h0100 * (s1 - 2) + 4) : 16'h0000;
                expb16 = (exp16 == 16'h0000) ? 16'h0000 : exp16 + 16'h8000;
                check("n4_a_lane3", a_out1[3*DW1 +: DW1], exp16);
                check("n4_b_lane3", b_out1[3*DW1 +: DW1], expb16);
                if (first_nz < 0 && a_out1[3*DW1 +: DW1] != 16'h0000) first_nz = s1;
                s1++;
            end
            if (push1) begin
                if (push_diag1 !== PW1'(exp_d1)) diag_bad1++;
                exp_d1++;
                n_push1++;
            end
            if (done1) n_done1++;
        end
        check("n4_first_nz", first_nz, 3);
        check("n4_steps", s1, 7);
        check("n4_beats", nb1, 4);
        check("n4_drain", n_drain1, 3);
        check("n4_push_cnt", n_push1, 7);
        check("n4_diag", diag_bad1, 0);
        check("n4_done_cnt", n_done1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
